// File: rtl/ac_match_reporter_pkg.sv
// Shared defaults and record-layout helper for the Aho-Corasick match reporter.
package ac_match_reporter_pkg;

    localparam int AC_STATE_W = 8;
    localparam int AC_NPAT    = 4;
    localparam int AC_PID_W   = 2;
    localparam int AC_POS_W   = 16;
    localparam int AC_FDEPTH  = 8;

    // Match record is packed as {pattern id, text position}.
    function automatic int ac_rec_w(input int pid_w, input int pos_w);
        return pid_w + pos_w;
    endfunction

endpackage

// File: rtl/ac_match_fifo.sv
// Synchronous match-record FIFO; no pass-through, output forced to zero while empty.
module ac_match_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices coincide.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ac_match_reporter.sv
// Output-function lookup and per-pattern serialisation of the Aho-Corasick state stream.
module ac_match_reporter
    import ac_match_reporter_pkg::*;
#(
    parameter int STATE_W = AC_STATE_W,
    parameter int NPAT    = AC_NPAT,
    parameter int PID_W   = AC_PID_W,
    parameter int POS_W   = AC_POS_W,
    parameter int FDEPTH  = AC_FDEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               state_vld,
    output logic               state_rdy,
    input  logic [STATE_W-1:0] now_state,
    input  logic               tbl_we,
    input  logic [STATE_W-1:0] tbl_addr,
    input  logic [NPAT-1:0]    tbl_data,
    output logic               m_vld,
    input  logic               m_rdy,
    output logic [PID_W-1:0]   m_pid,
    output logic [POS_W-1:0]   m_pos
);
    localparam int REC_W = ac_rec_w(PID_W, POS_W);

    function automatic logic [PID_W-1:0] lowest_id(input logic [NPAT-1:0] m);
        lowest_id = '0;
        for (int i = NPAT - 1; i >= 0; i--) begin
            if (m[i]) lowest_id = PID_W'(i);
        end
    endfunction

    logic [NPAT-1:0]  tbl [2**STATE_W];

    logic [POS_W-1:0] pos_p0;
    logic             vld_p1;
    logic [NPAT-1:0]  mask_p1;
    logic [POS_W-1:0] pos_p1;
    logic [NPAT-1:0]  mask_p2;
    logic [POS_W-1:0] pos_p2;

    logic             accept;
    logic [NPAT-1:0]  low_bit;
    logic             push;
    logic             b_load;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] fifo_din;
    logic [REC_W-1:0] fifo_dout;

    assign low_bit   = mask_p2 & (~mask_p2 + NPAT'(1));
    assign push      = (|mask_p2) && !fifo_full;
    // B takes a new state when empty or when the bit being pushed is its last one.
    assign b_load    = !(|mask_p2) || (push && !(|(mask_p2 & ~low_bit)));
    assign state_rdy = !vld_p1 || b_load;
    assign accept    = en && state_vld && state_rdy;
    assign fifo_din  = {lowest_id(mask_p2), pos_p2};

    always_ff @(posedge clk) begin
        if (tbl_we) tbl[tbl_addr] <= tbl_data;
    end

    // Stage p0 -> p1: position tag and table read (old data on write collision).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_p0  <= '0;
            vld_p1  <= 1'b0;
            mask_p1 <= '0;
            pos_p1  <= '0;
        end else begin
            if (accept) pos_p0 <= pos_p0 + 1'b1;
            if (state_rdy) begin
                vld_p1 <= accept;
                if (accept) begin
                    mask_p1 <= tbl[now_state];
                    pos_p1  <= pos_p0;
                end
            end
        end
    end

    // Stage p1 -> p2: serialiser, one record per set bit, lowest id first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_p2 <= '0;
            pos_p2  <= '0;
        end else if (b_load) begin
            mask_p2 <= vld_p1 ? mask_p1 : '0;
            pos_p2  <= pos_p1;
        end else if (push) begin
            mask_p2 <= mask_p2 & ~low_bit;
        end
    end

    ac_match_fifo #(
        .W     (REC_W),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (fifo_din),
        .full  (fifo_full),
        .pop   (m_rdy),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    assign m_vld = !fifo_empty;
    assign m_pid = fifo_dout[REC_W-1 -: PID_W];
    assign m_pos = fifo_dout[POS_W-1:0];

endmodule
